// File: rtl/prom_arb_defs.vh
// prom_arb_defs: 2-bit state encodings shared by the PROM arbiter and anything that decodes its state.
`ifndef PROM_ARB_DEFS_VH
`define PROM_ARB_DEFS_VH
`define PROM_ARB_IDLE  2'd0
`define PROM_ARB_ISSUE 2'd1
`define PROM_ARB_WAIT  2'd2
`define PROM_ARB_RESP  2'd3
`endif

// File: rtl/prom_arb.sv
// prom_arb: two-master arbiter in front of a toggle-ack PROM; writes complete locally with an error pulse.
`include "prom_arb_defs.vh"
module prom_arb #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [11:2] m0_addr,
    output logic [31:0] m0_data_out,
    output logic        m0_ack,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [11:2] m1_addr,
    output logic [31:0] m1_data_out,
    output logic        m1_ack,
    output logic        m_wr_err,
    output logic        p_stb,
    output logic        p_we,
    output logic [11:2] p_addr,
    input  logic [31:0] p_data_in,
    input  logic        p_ack
);
    typedef enum logic [1:0] {
        IDLE  = `PROM_ARB_IDLE,
        ISSUE = `PROM_ARB_ISSUE,
        WAIT  = `PROM_ARB_WAIT,
        RESP  = `PROM_ARB_RESP
    } state_t;
    state_t      state_q, state_d;
    logic        gnt_q, gnt_d, last_q, last_d, wr_q, wr_d, ack_ref_q, ack_ref_d;
    logic [31:0] d0_q, d0_d, d1_q, d1_d;
    logic        pick, pick_we;
    // m1 wins only when alone, or on a round-robin tie after m0 was served last
    assign pick    = m1_stb && !(m0_stb && (FIXED_PRIO != 0 || last_q));
    assign pick_we = pick ? m1_we : m0_we;
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        wr_d      = wr_q;
        ack_ref_d = ack_ref_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        case (state_q)
            IDLE: if (m0_stb || m1_stb) begin
                gnt_d   = pick;
                last_d  = pick;
                wr_d    = pick_we;
                state_d = pick_we ? RESP : ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (p_ack != ack_ref_q) begin
                ack_ref_d = p_ack;
                d0_d      = gnt_q ? d0_q : p_data_in;
                d1_d      = gnt_q ? p_data_in : d1_q;
                state_d   = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            wr_q      <= 1'b0;
            ack_ref_q <= 1'b0;
            d0_q      <= '0;
            d1_q      <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            ack_ref_q <= ack_ref_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
        end
    end
    assign m0_ack      = state_q == RESP && !gnt_q;
    assign m1_ack      = state_q == RESP && gnt_q;
    assign m_wr_err    = state_q == RESP && wr_q;
    assign p_stb       = state_q == ISSUE;
    assign p_we        = 1'b0;
    assign p_addr      = p_stb ? (gnt_q ? m1_addr : m0_addr) : '0;
    assign m0_data_out = d0_q;
    assign m1_data_out = d1_q;
endmodule

// File: tb/tb_prom_arb.sv
// tb_prom_arb: directed requests push expected acks into per-master queues; a negedge monitor pops and compares.
module tb_prom_arb;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m0_stb = 0, m0_we = 0, m1_stb = 0, m1_we = 0;
    logic [11:2] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_data_out, m1_data_out, p_data_in;
    logic        m0_ack, m1_ack, m_wr_err, p_stb, p_we, p_ack;
    logic [11:2] p_addr;

    logic        f_m0_stb = 0, f_m1_stb = 0;
    logic [11:2] f_m0_addr = 10'h005, f_m1_addr = 10'h006;
    logic [31:0] f_m0_data_out, f_m1_data_out, f_p_data_in;
    logic        f_m0_ack, f_m1_ack, f_wr_err, f_p_stb, f_p_we, f_p_ack;
    logic [11:2] f_p_addr;

    prom_arb #(.FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst(rst),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_data_out(m0_data_out), .m0_ack(m0_ack),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_data_out(m1_data_out), .m1_ack(m1_ack),
        .m_wr_err(m_wr_err), .p_stb(p_stb), .p_we(p_we), .p_addr(p_addr),
        .p_data_in(p_data_in), .p_ack(p_ack)
    );
    prom_arb #(.FIXED_PRIO(1)) u_fix (
        .clk(clk), .rst(rst),
        .m0_stb(f_m0_stb), .m0_we(1'b0), .m0_addr(f_m0_addr), .m0_data_out(f_m0_data_out), .m0_ack(f_m0_ack),
        .m1_stb(f_m1_stb), .m1_we(1'b0), .m1_addr(f_m1_addr), .m1_data_out(f_m1_data_out), .m1_ack(f_m1_ack),
        .m_wr_err(f_wr_err), .p_stb(f_p_stb), .p_we(f_p_we), .p_addr(f_p_addr),
        .p_data_in(f_p_data_in), .p_ack(f_p_ack)
    );

    function automatic logic [31:0] word(input logic [9:0] a);
        return a == 10'h005 ? 32'hDEADBEEF : 32'hA500_0000 | {22'd0, a};
    endfunction

    // compatible PROM: samples p_stb and answers one edge later by toggling p_ack
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ack <= 1'b0;
            p_data_in <= '0;
        end else if (p_stb) begin
            p_ack <= ~p_ack;
            p_data_in <= word(p_addr);
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_p_ack <= 1'b0;
            f_p_data_in <= '0;
        end else if (f_p_stb) begin
            f_p_ack <= ~f_p_ack;
            f_p_data_in <= word(f_p_addr);
        end
    end
    int pstb_cnt = 0;
    always @(posedge clk) if (p_stb) pstb_cnt <= pstb_cnt + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q0[$], q1[$];

    logic [31:0] prev0 = '0, prev1 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m0_ack) begin
                if (q0.size() == 0) chk("m0 unexpected ack", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("m0 ack cycle", cyc, e.cyc);
                    chk("m0 data_out", m0_data_out, e.data);
                    chk("m0 wr_err", 32'(m_wr_err), 32'(e.err));
                end
            end
            if (m1_ack) begin
                if (q1.size() == 0) chk("m1 unexpected ack", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("m1 ack cycle", cyc, e.cyc);
                    chk("m1 data_out", m1_data_out, e.data);
                    chk("m1 wr_err", 32'(m_wr_err), 32'(e.err));
                end
            end
            if (m0_data_out !== prev0 && !(m0_ack && !m_wr_err)) chk("m0 data_out stable", m0_data_out, prev0);
            if (m1_data_out !== prev1 && !(m1_ack && !m_wr_err)) chk("m1 data_out stable", m1_data_out, prev1);
            if (!p_stb) chk("p_addr zero when idle", 32'(p_addr), 32'd0);
            if (!f_p_stb) chk("fixed p_addr zero when idle", 32'(f_p_addr), 32'd0);
        end
        prev0 <= m0_data_out;
        prev1 <= m1_data_out;
    end

    // issue one request; off is the hand-computed ack cycle relative to the sampling edge N
    task automatic req(input bit m, input bit we, input logic [9:0] a, input logic [31:0] d, input int off);
        exp_t e;
        bit got;
        e.data = d;
        e.err = we;
        e.cyc = cyc + 1 + off;
        got = 0;
        if (m) begin
            q1.push_back(e);
            m1_we = we; m1_addr = a; m1_stb = 1;
        end else begin
            q0.push_back(e);
            m0_we = we; m0_addr = a; m0_stb = 1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = m ? m1_ack : m0_ack;
        end
        if (!got) chk(m ? "m1 ack timeout" : "m0 ack timeout", 32'd0, 32'd1);
        if (m) m1_stb = 0; else m0_stb = 0;
        @(negedge clk);
    endtask

    initial begin
        int c0, c1, ps;
        repeat (2) @(negedge clk);
        chk("rst p_stb", 32'(p_stb), 32'd0);
        chk("rst m0_data_out", m0_data_out, 32'd0);
        rst = 0;
        @(negedge clk);
        chk("idle acks", 32'({m0_ack, m1_ack, m_wr_err}), 32'd0);
        chk("idle m1_data_out", m1_data_out, 32'd0);
        chk("p_we tied low", 32'(p_we), 32'd0);
        fork
            req(0, 0, 10'h002, 32'hA500_0002, 2);
            req(1, 0, 10'h003, 32'hA500_0003, 6);
        join
        fork
            req(0, 0, 10'h002, 32'hA500_0002, 2);
            req(1, 0, 10'h003, 32'hA500_0003, 6);
        join
        req(0, 0, 10'h005, 32'hDEADBEEF, 2);
        fork
            req(1, 0, 10'h006, 32'hA500_0006, 2);
            req(0, 0, 10'h007, 32'hA500_0007, 6);
        join
        ps = pstb_cnt;
        req(1, 1, 10'h010, 32'hA500_0006, 0);
        chk("write p_stb count", 32'(pstb_cnt - ps), 32'd0);
        chk("write keeps m1_data_out", m1_data_out, 32'hA500_0006);
        req(0, 0, 10'h000, 32'hA500_0000, 2);
        req(0, 0, 10'h001, 32'hA500_0001, 2);
        m0_we = 0; m0_addr = 10'h004; m0_stb = 1;
        @(negedge clk);
        chk("issue p_stb", 32'(p_stb), 32'd1);
        chk("issue p_addr", 32'(p_addr), 32'h004);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid-wait rst p_stb", 32'(p_stb), 32'd0);
        chk("mid-wait rst acks", 32'({m0_ack, m1_ack, m_wr_err}), 32'd0);
        chk("mid-wait rst m0_data_out", m0_data_out, 32'd0);
        chk("mid-wait rst m1_data_out", m1_data_out, 32'd0);
        m0_stb = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        req(0, 0, 10'h005, 32'hDEADBEEF, 2);
        c0 = 0; c1 = 0;
        f_m0_stb = 1; f_m1_stb = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c0 += int'(f_m0_ack);
            c1 += int'(f_m1_ack);
        end
        f_m0_stb = 0; f_m1_stb = 0;
        chk("fixed m0 grants", c0, 32'd10);
        chk("fixed m1 grants", c1, 32'd0);
        chk("fixed m0_data_out", f_m0_data_out, 32'hDEADBEEF);
        chk("fixed m1_data_out", f_m1_data_out, 32'd0);
        repeat (4) @(negedge clk);
        chk("m0 queue drained", q0.size(), 32'd0);
        chk("m1 queue drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prom_arb.md
PROM_ARB -- requirements
Module: prom_arb

Interface
REQ-001 SHALL provide parameter FIXED_PRIO, default 0: 0 = round-robin arbitration, 1 = master 0 always wins.
REQ-002 SHALL have port clk  input  1  single system clock, all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports m0_stb / m1_stb  input  1  master request, held high until that master's ack.
REQ-005 SHALL have ports m0_we / m1_we  input  1  master write flag, stable while stb is high.
REQ-006 SHALL have ports m0_addr / m1_addr  input  [11:2]  master word address, stable while stb is high.
REQ-007 SHALL have ports m0_data_out / m1_data_out  output  32  registered read data to the master.
REQ-008 SHALL have ports m0_ack / m1_ack  output  1  one-cycle completion pulse to the master.
REQ-009 SHALL have port m_wr_err  output  1  one-cycle pulse when a write to PROM space is completed.
REQ-010 SHALL have ports p_stb  output  1, p_we  output  1 (tied 0), p_addr  output  [11:2]  PROM request side.
REQ-011 SHALL have ports p_data_in  input  32, p_ack  input  1  PROM read data and toggle-style ack.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-013 In IDLE with no stb high, SHALL stay in IDLE.
REQ-014 In IDLE with exactly one stb high, SHALL grant that master.
REQ-015 In IDLE with both stb high, SHALL grant master 0 when FIXED_PRIO=1, else the master not granted last (last_grant resets to 1, so master 0 wins the first tie).
REQ-016 SHALL register the grant index and update last_grant at the grant edge.
REQ-017 From IDLE, a granted read SHALL go to ISSUE; a granted write SHALL go to RESP with no PROM access and m_wr_err=1 in RESP.
REQ-018 ISSUE SHALL last exactly one cycle: p_stb=1, p_addr=granted master's addr; then go to WAIT.
REQ-019 In WAIT, p_stb SHALL be 0; completion SHALL be detected as p_ack != ack_ref, where ack_ref is a register holding the p_ack level of the previous completion.
REQ-020 On completion, SHALL capture p_data_in into the granted master's data_out, set ack_ref<=p_ack, and go to RESP; without completion, SHALL stay in WAIT indefinitely.
REQ-021 In RESP, SHALL assert only the granted master's ack for one cycle, then return to IDLE with no arbitration at that edge.
REQ-022 Read latency SHALL be: stb sampled in IDLE at edge N gives ack high during cycle N+3 with a compatible PROM.
REQ-023 Write latency SHALL be: ack high during cycle N+1; data_out of the write master SHALL be unchanged.
REQ-024 The non-granted master's stb SHALL be held pending, and it SHALL be served at the next IDLE.
REQ-025 data_out of a master SHALL change only on that master's read completion.
REQ-026 p_addr SHALL be 0 whenever p_stb=0.

Reset
REQ-027 Asserting rst at any time, including mid-ISSUE/WAIT/RESP, SHALL immediately force state=IDLE, p_stb=0, all acks=0, m_wr_err=0, both data_out=0, ack_ref=0, last_grant=1.
REQ-028 An in-flight transfer aborted by reset SHALL NOT be acked; masters reissue it.

Structure
REQ-029 State encodings (2-bit) SHALL live in the shared include file prom_arb_defs.vh; no package types.
REQ-030 The block SHALL be a single flat module; no sub-module.

Verification
REQ-031 The bench SHALL cover: m0 read addr 0x005, PROM word 0xDEADBEEF -> m0_ack in cycle N+3, m0_data_out=0xDEADBEEF, m1_ack stays 0.
REQ-032 The bench SHALL cover: m0 and m1 read simultaneously after reset -> m0 served first, m1 acked 4 cycles later; repeated ties alternate 0,1,0,1.
REQ-033 The bench SHALL cover: FIXED_PRIO=1 with both masters continuously requesting -> every grant goes to m0.
REQ-034 The bench SHALL cover: m1 write addr 0x010 -> m1_ack and m_wr_err high in cycle N+1, p_stb never asserted, m1_data_out unchanged.
REQ-035 The bench SHALL cover: two back-to-back m0 reads (0x000, 0x001) -> both complete via ack toggle detection with correct distinct data, with no stale-ack early completion.
REQ-036 The bench SHALL cover: rst pulse during WAIT -> outputs zero immediately, no ack issued, and the next read completes normally.
